sp_ram_ctrl: RTL and testbench
==============================

// Module: sp_ram_ctrl
// PURPOSE
//  Parametrised single-port block RAM: next generation of the SP primitive model, synthesisable and simulatable.
//  Adds configurable depth and width, byte-enable writes, three write modes and a DO_VALID tag.
//  Adds out-of-range address protection and a post-reset memory-clear sequencer.
//  Sits between datapath buffers (sample/line stores) and inferred BRAM.
// PARAMETERS
//  DATA_W      16  data word width (bits); must be a multiple of BYTE_W
//  BYTE_W      8   byte-enable granularity; NUM_BE = DATA_W/BYTE_W
//  DEPTH       1024  number of words; need not be a power of 2; ADDR_W = $clog2(DEPTH)
//  READ_MODE   0   0 = BYPASS (DO valid 1 cycle after access), 1 = PIPELINE (2 cycles, gated by OCE)
//  WRITE_MODE  0   0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
//  CLEAR_ON_RESET  1   1 = zero every word after RESET deasserts
// PORTS
//  CLK       in   1       clock; all logic on the rising edge
//  RESET     in   1       asynchronous, active-high reset
//  CE        in   1       access enable; ignored while BUSY=1
//  OCE       in   1       output register enable; PIPELINE mode only
//  WRE       in   1       1 = write, 0 = read; qualified by CE
//  BE        in   NUM_BE  byte enables for writes; bit i covers DI[i*BYTE_W +: BYTE_W]
//  AD        in   ADDR_W  word address
//  DI        in   DATA_W  write data
//  DO        out  DATA_W  read data
//  DO_VALID  out  1       single-cycle pulse when DO carries the result of an access
//  BUSY      out  1       1 while the clear sequencer owns the array
// BEHAVIOUR
//  Reset (async assert): DO=0, DO_VALID=0, pipe stage and its valid=0, BUSY=CLEAR_ON_RESET, FSM=CLEAR (or IDLE).
//  The memory array itself is never reset by RESET.
//  Reset asserted mid-clear or mid-access: everything above returns to reset values.
//  Clear then restarts at address 0 after deassert; a partially cleared array is not a fault.
//  FSM IDLE: accept accesses.
//  FSM CLEAR: write 0 to clr_addr each cycle; clr_addr counts 0..DEPTH-1.
//  After writing DEPTH-1, go to IDLE; BUSY drops on that same edge.
//  Clear therefore takes exactly DEPTH cycles after the first post-reset edge.
//  Access = IDLE & CE.
//  Write access: for each i with BE[i]=1, mem[AD] byte i <= DI byte i; other bytes unchanged.
//  A write with BE=0 is still an access (no data changes).
//  Read data per access, rd_word:
//    read: rd_word = mem[AD].
//    WRITE_FIRST write: rd_word = merged word (new bytes where BE=1, old elsewhere).
//    READ_FIRST write: rd_word = old mem[AD].
//    NO_CHANGE write: no result; DO holds and no DO_VALID is produced.
//  Out-of-range AD >= DEPTH: write dropped; rd_word = 0; DO_VALID still produced (not an error).
//  BYPASS: DO <= rd_word and DO_VALID <= 1 on the access edge; otherwise DO holds and DO_VALID <= 0.
//  PIPELINE:
//    Access edge: stage <= rd_word, stage_v <= 1; otherwise stage_v <= 0.
//    OCE=1: DO <= stage, DO_VALID <= stage_v.
//    OCE=0: DO holds, DO_VALID <= 0; that stage result is lost (matches vendor primitive).
//  Back-to-back accesses sustain one per cycle in both modes; no backpressure.
//  CE asserted while BUSY: dropped silently; no write, no DO_VALID.
// STRUCTURE
//  sp_ram_pkg holds:
//    typedef enum {WRITE_FIRST, READ_FIRST, NO_CHANGE} sp_wmode_e
//    typedef enum {RD_BYPASS, RD_PIPELINE} sp_rmode_e
//    typedef enum {ST_IDLE, ST_CLEAR} sp_clr_state_e
//  Sub-module sp_ram_array: unreset DEPTH x DATA_W storage with per-byte write and sync read.
//  sp_ram_array is the only inference target.
//  Top level: clear FSM, address range check, port mux (clear vs user), write-mode merge, output pipe.
//  Elaboration $error if DATA_W % BYTE_W != 0, WRITE_MODE > 2 or DEPTH < 2.
// TESTING
//  Clear: DEPTH=1024, CLEAR_ON_RESET=1, release RESET -> BUSY high exactly 1024 cycles; reading every address returns 0.
//  Byte write: WRITE_FIRST, mem[5]=16'hA5A5, write DI=16'h1234 BE=2'b01 AD=5 -> DO=16'hA534 next cycle; later read AD=5 -> 16'hA534.
//  Write modes: mem[7]=16'h0001, write 16'h00FF AD=7.
//    READ_FIRST -> DO=16'h0001.
//    NO_CHANGE -> DO holds previous value, DO_VALID=0.
//  Pipeline: READ_MODE=1, reads AD=1,2,3 back-to-back with OCE=1 -> DO_VALID pulses 2 cycles after each read, data in order.
//  Pipeline OCE=0 mid-stream -> that result is dropped.
//  Boundary: DEPTH=1000, write AD=1000 -> no array change; read AD=1000 -> DO=0 with DO_VALID=1.
//  Reset mid-clear: assert RESET at clear cycle 300 -> DO/DO_VALID=0 asynchronously.
//  After release, BUSY high DEPTH cycles again; CE during BUSY produces no DO_VALID.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM controller: write/read mode tags and clear FSM states.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } sp_wmode_e;

    typedef enum logic {
        RD_BYPASS   = 1'b0,
        RD_PIPELINE = 1'b1
    } sp_rmode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sp_clr_state_e;

endpackage

// File: rtl/sp_ram_ctrl_if.sv
// User-side access bus of the single-port RAM controller.
interface sp_ram_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned DEPTH  = 1024
);
    localparam int unsigned NUM_BE = DATA_W / BYTE_W;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              CE;
    logic              OCE;
    logic              WRE;
    logic [NUM_BE-1:0] BE;
    logic [ADDR_W-1:0] AD;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic              DO_VALID;
    logic              BUSY;

    modport master (output CE, OCE, WRE, BE, AD, DI, input DO, DO_VALID, BUSY);
    modport slave  (input CE, OCE, WRE, BE, AD, DI, output DO, DO_VALID, BUSY);

endinterface

// File: rtl/sp_ram_array.sv
// Unreset DEPTH x DATA_W storage with per-byte write enables and a registered read-first read port.
module sp_ram_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic                       re,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);
    localparam int unsigned NUM_BE = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NUM_BE; i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: post-reset clear sequencer, range check, write-mode merge and output pipe.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned READ_MODE      = 0,
    parameter int unsigned WRITE_MODE     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    sp_ram_ctrl_if.slave bus
);
    localparam int unsigned   NUM_BE    = DATA_W / BYTE_W;
    localparam int unsigned   ADDR_W    = $clog2(DEPTH);
    localparam sp_wmode_e     WMODE     = sp_wmode_e'(WRITE_MODE[1:0]);
    localparam sp_rmode_e     RMODE     = sp_rmode_e'(READ_MODE[0]);
    localparam sp_clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("sp_ram_ctrl: DATA_W must be a multiple of BYTE_W");
    end
    if (WRITE_MODE > 2) begin : g_bad_wmode
        $error("sp_ram_ctrl: WRITE_MODE must be 0, 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sp_ram_ctrl: DEPTH must be at least 2");
    end

    sp_clr_state_e     state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              hit_q, hit_d;
    logic              have_q, have_d;
    logic              zero_q, zero_d;
    logic              merge_q, merge_d;
    logic [NUM_BE-1:0] be_q, be_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              dv_q, dv_d;

    logic              acc_c, in_range_c, produce_c;
    logic              arr_we, arr_re;
    logic [NUM_BE-1:0] arr_be;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic [DATA_W-1:0] stage_c;

    // Clear FSM, port mux and capture of the per-access tag that shapes rd_word.
    always_comb begin : p_next
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        hit_d      = 1'b0;
        have_d     = have_q;
        zero_d     = zero_q;
        merge_d    = merge_q;
        be_d       = be_q;
        di_d       = di_q;

        acc_c      = (state_q == ST_IDLE) && bus.CE;
        in_range_c = (32'(bus.AD) < DEPTH);
        produce_c  = acc_c && !(bus.WRE && (WMODE == NO_CHANGE));

        arr_we    = acc_c && bus.WRE && in_range_c;
        arr_re    = produce_c && in_range_c;
        arr_be    = bus.BE;
        arr_addr  = bus.AD;
        arr_wdata = bus.DI;

        case (state_q)
            ST_CLEAR: begin
                arr_we     = 1'b1;
                arr_be     = '1;
                arr_addr   = clr_addr_q;
                arr_wdata  = '0;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase

        if (produce_c) begin
            hit_d   = 1'b1;
            have_d  = 1'b1;
            zero_d  = !in_range_c;
            merge_d = bus.WRE && (WMODE == WRITE_FIRST);
            be_d    = bus.BE;
            di_d    = bus.DI;
        end
    end

    // The array read register doubles as the pipeline stage; the tag selects old, merged or zero.
    always_comb begin : p_rd_word
        stage_c = arr_rdata;
        if (merge_q) begin
            for (int unsigned i = 0; i < NUM_BE; i++) begin
                if (be_q[i]) begin
                    stage_c[i*BYTE_W +: BYTE_W] = di_q[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (zero_q || !have_q) begin
            stage_c = '0;
        end
    end

    always_comb begin : p_out_reg
        do_d = do_q;
        dv_d = 1'b0;
        if (bus.OCE) begin
            do_d = stage_c;
            dv_d = hit_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            hit_q      <= 1'b0;
            have_q     <= 1'b0;
            zero_q     <= 1'b0;
            merge_q    <= 1'b0;
            be_q       <= '0;
            di_q       <= '0;
            do_q       <= '0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            hit_q      <= hit_d;
            have_q     <= have_d;
            zero_q     <= zero_d;
            merge_q    <= merge_d;
            be_q       <= be_d;
            di_q       <= di_d;
            do_q       <= do_d;
            dv_q       <= dv_d;
        end
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .re    (arr_re),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign bus.DO       = (RMODE == RD_PIPELINE) ? do_q : stage_c;
    assign bus.DO_VALID = (RMODE == RD_PIPELINE) ? dv_q : hit_q;
    assign bus.BUSY     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench: four controller variants share one stimulus bus; a vector table plus hand sequences.
module tb_sp_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, oce, wre;
    logic [1:0]  be;
    logic [9:0]  ad;
    logic [15:0] di;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sp_ram_ctrl_if #(.DATA_W(16), .BYTE_W(8), .DEPTH(1024)) if0 ();
    sp_ram_ctrl_if #(.DATA_W(16), .BYTE_W(8), .DEPTH(1000)) if1 ();
    sp_ram_ctrl_if #(.DATA_W(16), .BYTE_W(8), .DEPTH(1000)) if2 ();
    sp_ram_ctrl_if #(.DATA_W(16), .BYTE_W(8), .DEPTH(1024)) if3 ();

    assign if0.CE = ce, if0.OCE = oce, if0.WRE = wre, if0.BE = be, if0.AD = ad, if0.DI = di;
    assign if1.CE = ce, if1.OCE = oce, if1.WRE = wre, if1.BE = be, if1.AD = ad, if1.DI = di;
    assign if2.CE = ce, if2.OCE = oce, if2.WRE = wre, if2.BE = be, if2.AD = ad, if2.DI = di;
    assign if3.CE = ce, if3.OCE = oce, if3.WRE = wre, if3.BE = be, if3.AD = ad, if3.DI = di;

    // u0: bypass/write-first, u1: bypass/read-first, u2: bypass/no-change, u3: pipeline/write-first
    sp_ram_ctrl #(.DEPTH(1024), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
        u0 (.CLK(clk), .RESET(rst), .bus(if0));
    sp_ram_ctrl #(.DEPTH(1000), .READ_MODE(0), .WRITE_MODE(1), .CLEAR_ON_RESET(1))
        u1 (.CLK(clk), .RESET(rst), .bus(if1));
    sp_ram_ctrl #(.DEPTH(1000), .READ_MODE(0), .WRITE_MODE(2), .CLEAR_ON_RESET(1))
        u2 (.CLK(clk), .RESET(rst), .bus(if2));
    sp_ram_ctrl #(.DEPTH(1024), .READ_MODE(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
        u3 (.CLK(clk), .RESET(rst), .bus(if3));

    typedef struct {
        logic        ce;
        logic        wre;
        logic [1:0]  be;
        logic [9:0]  ad;
        logic [15:0] di;
        logic [15:0] e0;
        logic        v0;
        logic [15:0] e1;
        logic        v1;
        logic [15:0] e2;
        logic        v2;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and counts BUSY-high samples per variant; CE stays on while the arrays are busy.
    task automatic run_clear(input logic use_ce, input string tag);
        int c0, c1, c2, c3, nv;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; nv = 0;
        ce = use_ce; wre = 1'b1; be = 2'b11; ad = 10'd5; di = 16'hDEAD; oce = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            if (if0.BUSY) c0++;
            if (if1.BUSY) c1++;
            if (if2.BUSY) c2++;
            if (if3.BUSY) c3++;
            if (if0.DO_VALID) nv++;
            if (if1.DO_VALID) nv++;
            if (if2.DO_VALID) nv++;
            if (if3.DO_VALID) nv++;
            if (!if1.BUSY) ce = 1'b0;
            tick();
        end
        ce = 1'b0;
        check({tag, " busy cycles u0"}, 32'(c0), 32'd1024);
        check({tag, " busy cycles u1"}, 32'(c1), 32'd1000);
        check({tag, " busy cycles u2"}, 32'(c2), 32'd1000);
        check({tag, " busy cycles u3"}, 32'(c3), 32'd1024);
        check({tag, " valid while busy"}, 32'(nv), 32'd0);
    endtask

    initial begin
        int e0, e1;

        vecs[0]  = '{1'b1, 1'b1, 2'b11, 10'd5,    16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 10'd5,    16'h1234, 16'hA534, 1'b1, 16'hA5A5, 1'b1, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 10'd5,    16'h0000, 16'hA534, 1'b1, 16'hA534, 1'b1, 16'hA534, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 10'd7,    16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 16'hA534, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 10'd7,    16'h00FF, 16'h00FF, 1'b1, 16'h0001, 1'b1, 16'hA534, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b11, 10'd7,    16'h0000, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 2'b00, 10'd7,    16'hFFFF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 10'd7,    16'h0000, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 2'b11, 10'd1000, 16'hBEEF, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 16'h00FF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 10'd1000, 16'h0000, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'b10, 10'd999,  16'h0F0F, 16'h0F00, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'b11, 10'd999,  16'h0000, 16'h0F00, 1'b1, 16'h0F00, 1'b1, 16'h0F00, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 10'd999,  16'h0000, 16'h0F00, 1'b0, 16'h0F00, 1'b0, 16'h0F00, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 10'd1001, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};

        rst = 1'b1; ce = 1'b0; oce = 1'b0; wre = 1'b0; be = 2'b00; ad = '0; di = '0;
        repeat (3) tick();
        check("reset DO u0",       32'(if0.DO),       32'h0);
        check("reset DO_VALID u0", 32'(if0.DO_VALID), 32'h0);
        check("reset BUSY u0",     32'(if0.BUSY),     32'h1);
        check("reset DO u3",       32'(if3.DO),       32'h0);
        check("reset DO_VALID u3", 32'(if3.DO_VALID), 32'h0);

        run_clear(1'b0, "clr1");

        for (int i = 0; i < NVEC; i++) begin
            ce = vecs[i].ce; wre = vecs[i].wre; be = vecs[i].be; ad = vecs[i].ad; di = vecs[i].di;
            tick();
            check($sformatf("vec%0d DO u0", i),       32'(if0.DO),       32'(vecs[i].e0));
            check($sformatf("vec%0d DO_VALID u0", i), 32'(if0.DO_VALID), 32'(vecs[i].v0));
            check($sformatf("vec%0d DO u1", i),       32'(if1.DO),       32'(vecs[i].e1));
            check($sformatf("vec%0d DO_VALID u1", i), 32'(if1.DO_VALID), 32'(vecs[i].v1));
            check($sformatf("vec%0d DO u2", i),       32'(if2.DO),       32'(vecs[i].e2));
            check($sformatf("vec%0d DO_VALID u2", i), 32'(if2.DO_VALID), 32'(vecs[i].v2));
        end

        // Pipeline variant: load words 1..3 with the output register frozen, then let it settle.
        oce = 1'b0; ce = 1'b1; wre = 1'b1; be = 2'b11;
        ad = 10'd1; di = 16'h1111; tick();
        ad = 10'd2; di = 16'h2222; tick();
        ad = 10'd3; di = 16'h3333; tick();
        ce = 1'b0; oce = 1'b1; wre = 1'b0;
        repeat (3) tick();

        ce = 1'b1; ad = 10'd1; tick();
        check("pipe latency DO_VALID", 32'(if3.DO_VALID), 32'h0);
        ad = 10'd2; tick();
        check("pipe rd1 DO",       32'(if3.DO),       32'h1111);
        check("pipe rd1 DO_VALID", 32'(if3.DO_VALID), 32'h1);
        ad = 10'd3; tick();
        check("pipe rd2 DO",       32'(if3.DO),       32'h2222);
        check("pipe rd2 DO_VALID", 32'(if3.DO_VALID), 32'h1);
        ce = 1'b0; tick();
        check("pipe rd3 DO",       32'(if3.DO),       32'h3333);
        check("pipe rd3 DO_VALID", 32'(if3.DO_VALID), 32'h1);
        tick();
        check("pipe idle DO_VALID", 32'(if3.DO_VALID), 32'h0);

        ce = 1'b1; ad = 10'd1; tick();
        ad = 10'd2; tick();
        check("oce rd1 DO",       32'(if3.DO),       32'h1111);
        check("oce rd1 DO_VALID", 32'(if3.DO_VALID), 32'h1);
        ad = 10'd3; oce = 1'b0; tick();
        check("oce dropped DO",       32'(if3.DO),       32'h1111);
        check("oce dropped DO_VALID", 32'(if3.DO_VALID), 32'h0);
        ce = 1'b0; oce = 1'b1; tick();
        check("oce rd3 DO",       32'(if3.DO),       32'h3333);
        check("oce rd3 DO_VALID", 32'(if3.DO_VALID), 32'h1);
        tick();

        // Reset mid-access clears DO/DO_VALID without waiting for a clock edge.
        ce = 1'b1; wre = 1'b0; ad = 10'd5; tick();
        check("pre-reset DO u0",       32'(if0.DO),       32'hA534);
        check("pre-reset DO_VALID u0", 32'(if0.DO_VALID), 32'h1);
        ce = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async reset DO u0",       32'(if0.DO),       32'h0);
        check("async reset DO_VALID u0", 32'(if0.DO_VALID), 32'h0);
        check("async reset DO u1",       32'(if1.DO),       32'h0);
        check("async reset BUSY u0",     32'(if0.BUSY),     32'h1);
        tick(); tick();

        rst = 1'b0;
        repeat (300) tick();
        check("mid-clear BUSY u0", 32'(if0.BUSY), 32'h1);
        rst = 1'b1;
        #1;
        check("mid-clear reset DO u0",       32'(if0.DO),       32'h0);
        check("mid-clear reset DO_VALID u0", 32'(if0.DO_VALID), 32'h0);
        tick(); tick();

        run_clear(1'b1, "clr2");

        e0 = 0; e1 = 0;
        ce = 1'b1; wre = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            ad = 10'(a);
            tick();
            if (if0.DO !== 16'h0000 || if0.DO_VALID !== 1'b1) e0++;
            if (if1.DO !== 16'h0000 || if1.DO_VALID !== 1'b1) e1++;
        end
        ce = 1'b0;
        check("clear readback u0", 32'(e0), 32'd0);
        check("clear readback u1", 32'(e1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
